// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and oversampling constants.
// The same definitions are intended for the transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = 7;

    // Bit-counter width; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bus: serial line and oversample strobe in, received word and status out.
interface uart_rx_if #(
    parameter int DBIT = 8
);
    logic            rx;
    logic            s_tick;
    logic [DBIT-1:0] dout;
    logic            rx_done_tick;
    logic            frame_err;
    logic            parity_err;
    logic            busy;

    modport master (
        output rx, s_tick,
        input  dout, rx_done_tick, frame_err, parity_err, busy
    );

    modport slave (
        input  rx, s_tick,
        output dout, rx_done_tick, frame_err, parity_err, busy
    );
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous, idle-high input.
// Both stages reset to 1 so a reset never looks like a falling edge.
module uart_sync2 (
    input  logic clk,
    input  logic reset_n,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meta <= 1'b1;
            r_q    <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, 1 start, DBIT data LSB first, optional parity, stop.
// Parity bit and checking exist only when UART_RX_PARITY_EN is defined.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic     clk,
    input  logic     reset_n,
    uart_rx_if.slave bus
);
    localparam int N_W = cnt_width(DBIT);

    localparam logic [4:0]     MID_CNT  = 5'(MID_TICK);
    localparam logic [4:0]     BIT_LAST = 5'(OVERSAMPLE - 1);
    localparam logic [4:0]     STP_LAST = 5'(SB_TICK - 1);
    localparam logic [N_W-1:0] N_LAST   = N_W'(DBIT - 1);

    logic w_rx_s;

    rx_state_t       r_state,  w_state_next;
    logic [4:0]      r_s_cnt,  w_s_cnt_next;
    logic [N_W-1:0]  r_n,      w_n_next;
    logic [DBIT-1:0] r_shift,  w_shift_next;
    logic [DBIT-1:0] r_dout,   w_dout_next;
    logic            r_done,   w_done_next;
    logic            r_ferr,   w_ferr_next;
`ifdef UART_RX_PARITY_EN
    logic            r_par_bad, w_par_bad_next;
    logic            r_perr,    w_perr_next;
`endif

    uart_sync2 u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .i_d     (bus.rx),
        .o_q     (w_rx_s)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_s_cnt <= '0;
            r_n     <= '0;
            r_shift <= '0;
            r_dout  <= '0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= 1'b0;
            r_perr    <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            r_s_cnt <= w_s_cnt_next;
            r_n     <= w_n_next;
            r_shift <= w_shift_next;
            r_dout  <= w_dout_next;
            r_done  <= w_done_next;
            r_ferr  <= w_ferr_next;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= w_par_bad_next;
            r_perr    <= w_perr_next;
`endif
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_s_cnt_next = r_s_cnt;
        w_n_next     = r_n;
        w_shift_next = r_shift;
        w_dout_next  = r_dout;
        w_done_next  = 1'b0;
        w_ferr_next  = r_ferr;
`ifdef UART_RX_PARITY_EN
        w_par_bad_next = r_par_bad;
        w_perr_next    = r_perr;
`endif

        if (bus.s_tick) begin
            unique case (r_state)
                IDLE: begin
                    if (!w_rx_s) begin
                        w_state_next = START;
                        w_s_cnt_next = '0;
                    end
                end

                START: begin
                    // Mid start bit: a line that has gone high again was only a glitch.
                    if (r_s_cnt == MID_CNT) begin
                        if (!w_rx_s) begin
                            w_state_next = DATA;
                            w_s_cnt_next = '0;
                            w_n_next     = '0;
                        end else begin
                            w_state_next = IDLE;
                        end
                    end else begin
                        w_s_cnt_next = r_s_cnt + 5'd1;
                    end
                end

                DATA: begin
                    if (r_s_cnt == BIT_LAST) begin
                        w_s_cnt_next = '0;
                        w_shift_next = {w_rx_s, r_shift[DBIT-1:1]};
                        if (r_n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            w_state_next = PARITY;
`else
                            w_state_next = STOP;
`endif
                        end else begin
                            w_n_next = r_n + N_W'(1);
                        end
                    end else begin
                        w_s_cnt_next = r_s_cnt + 5'd1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (r_s_cnt == BIT_LAST) begin
                        w_par_bad_next = (^r_shift) ^ w_rx_s ^ PARITY_ODD[0];
                        w_s_cnt_next   = '0;
                        w_state_next   = STOP;
                    end else begin
                        w_s_cnt_next = r_s_cnt + 5'd1;
                    end
                end
`endif

                STOP: begin
                    if (r_s_cnt == STP_LAST) begin
                        w_dout_next  = r_shift;
                        w_ferr_next  = ~w_rx_s;
`ifdef UART_RX_PARITY_EN
                        w_perr_next  = r_par_bad;
`endif
                        w_done_next  = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_s_cnt_next = r_s_cnt + 5'd1;
                    end
                end

                default: w_state_next = IDLE;
            endcase
        end
    end

    assign bus.dout         = r_dout;
    assign bus.rx_done_tick = r_done;
    assign bus.frame_err    = r_ferr;
    assign bus.busy         = (r_state != IDLE);
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err   = r_perr;
`else
    // No parity bit on the line, so the sense setting has nothing to act on.
    assign bus.parity_err   = PARITY_ODD[0] & 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboarded bench for uart_rx: 8 data bits, 1 stop, 16x tick every 4 clk.
// Frames carry an even parity bit when UART_RX_PARITY_EN is defined.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int BIT_CLK = 64;

    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];

    uart_rx_if #(.DBIT(8)) bus ();

    uart_rx #(.DBIT(8), .SB_TICK(16), .PARITY_ODD(0)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        bus.s_tick = 1'b0;
        forever begin
            repeat (3) @(posedge clk);
            #1 bus.s_tick = 1'b1;
            @(posedge clk);
            #1 bus.s_tick = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest expected frame.
    initial begin
        logic prev_done;
        exp_t e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.rx_done_tick) begin
                n_checks++;
                if (prev_done) begin
                    n_errors++;
                    $display("FAIL done_width: rx_done_tick high for 2+ cycles");
                end else if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_done: strobe with dout=%0h, none expected", bus.dout);
                end else begin
                    e = exp_q.pop_front();
                    check("dout", 32'(bus.dout), 32'(e.d));
                    check("frame_err", 32'(bus.frame_err), 32'(e.fe));
                    check("parity_err", 32'(bus.parity_err), 32'(e.pe));
                    $display("frame: dout=%02h frame_err=%0b parity_err=%0b", bus.dout, bus.frame_err, bus.parity_err);
                end
            end
            prev_done = bus.rx_done_tick;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bus.rx = b;
        wait_clk(BIT_CLK);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dout"}, 32'(bus.dout), 32'h0);
        check({tag, "_done"}, 32'(bus.rx_done_tick), 32'h0);
        check({tag, "_frame_err"}, 32'(bus.frame_err), 32'h0);
        check({tag, "_parity_err"}, 32'(bus.parity_err), 32'h0);
        check({tag, "_busy"}, 32'(bus.busy), 32'h0);
    endtask

    // rst_bit >= 0 pulses reset_n during that data bit and expects no strobe.
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip,
                              input int rst_bit, input int gap_bits);
        exp_t e;
        logic par_b;
        e.d  = d;
        e.fe = ~stop_b;
`ifdef UART_RX_PARITY_EN
        e.pe = par_flip;
`else
        e.pe = 1'b0;
`endif
        if (rst_bit < 0) exp_q.push_back(e);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == rst_bit) begin
                bus.rx = d[i];
                wait_clk(20);
                reset_n = 1'b0;
                #1 check_reset_outputs("midreset");
                wait_clk(4);
                reset_n = 1'b1;
                wait_clk(40);
            end else begin
                send_bit(d[i]);
            end
        end
        par_b = (^d) ^ par_flip;
`ifdef UART_RX_PARITY_EN
        send_bit(par_b);
`endif
        send_bit(stop_b);
        for (int g = 0; g < gap_bits; g++) send_bit(1'b1);
    endtask

    initial begin
        bit busy_seen;
        reset_n = 1'b0;
        bus.rx  = 1'b1;
        wait_clk(5);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        wait_clk(20);

        send_frame(8'h55, 1'b1, 1'b0, -1, 0);
        check("busy_after_55", 32'(bus.busy), 32'h0);
        send_bit(1'b1);

        send_frame(8'hA3, 1'b1, 1'b0, -1, 0);
        send_frame(8'h0F, 1'b1, 1'b0, -1, 2);

        busy_seen = 1'b0;
        bus.rx = 1'b0;
        for (int c = 0; c < 16; c++) begin
            wait_clk(1);
            if (bus.busy) busy_seen = 1'b1;
        end
        bus.rx = 1'b1;
        for (int c = 0; c < 64; c++) begin
            wait_clk(1);
            if (bus.busy) busy_seen = 1'b1;
        end
        check("glitch_busy_pulse", 32'(busy_seen), 32'h1);
        check("glitch_back_idle", 32'(bus.busy), 32'h0);
        $display("glitch: busy_seen=%0b busy_now=%0b", busy_seen, bus.busy);

        send_frame(8'hC6, 1'b0, 1'b0, -1, 3);
        send_frame(8'h11, 1'b1, 1'b0, -1, 2);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0, -1, 2);
        send_frame(8'h07, 1'b1, 1'b1, -1, 2);
`endif

        send_frame(8'hFF, 1'b1, 1'b0, 3, 2);
        send_frame(8'h3C, 1'b1, 1'b0, -1, 2);

        wait_clk(200);
        check("pending_frames", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
